// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_unit
// Description : Decode, control pipeline, hazard/forwarding control and stall
//               counter for the 16-bit pipelined datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       inst_id,
    input  logic              id_valid,
    input  logic              redirect_ex,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              jmp_target,
    output logic              update_rr,
    output logic              slect_pc_src_id,
    output logic [2:0]        alu_control,
    output logic              imm,
    output logic              r_type,
    output logic              logical_signal,
    output logic              for_signal,
    output logic              branch_signal,
    output logic              bne,
    output logic              write_to_mem,
    output logic              load_mem,
    output logic              write_to_reg,
    output logic              load_wb,
    output logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_count
);
    localparam logic [3:0] c_OP_R    = 4'd0;
    localparam logic [3:0] c_OP_ANDI = 4'd1;
    localparam logic [3:0] c_OP_ADDI = 4'd2;
    localparam logic [3:0] c_OP_LW   = 4'd3;
    localparam logic [3:0] c_OP_SW   = 4'd4;
    localparam logic [3:0] c_OP_BEQ  = 4'd5;
    localparam logic [3:0] c_OP_BNE  = 4'd6;
    localparam logic [3:0] c_OP_FOR  = 4'd7;
    localparam logic [3:0] c_OP_JMP  = 4'd8;
    localparam logic [3:0] c_OP_CALL = 4'd9;
    localparam logic [3:0] c_OP_RET  = 4'd10;

    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_ADD = 3'b001;
    localparam logic [2:0] c_ALU_SUB = 3'b010;

    // ---------------- ID decode ----------------
    logic [3:0]        w_op;
    logic [2:0]        w_alu;
    logic              w_imm, w_rtype, w_logic, w_for, w_br, w_bne;
    logic              w_wmem, w_ld, w_wreg;
    logic [REG_AW-1:0] w_rd, w_rs, w_rt;
    logic              w_jump_op;

    assign w_op = inst_id[15:12];

    // rs/rt are left at zero when the instruction does not read them, and rd
    // is zero for non-writers, so hazard and forwarding compares stay simple.
    always_comb begin
        w_alu   = c_ALU_AND;
        w_imm   = 1'b0;
        w_rtype = 1'b0;
        w_logic = 1'b0;
        w_for   = 1'b0;
        w_br    = 1'b0;
        w_bne   = 1'b0;
        w_wmem  = 1'b0;
        w_ld    = 1'b0;
        w_wreg  = 1'b0;
        w_rd    = '0;
        w_rs    = '0;
        w_rt    = '0;
        case (w_op)
            c_OP_R: begin
                w_rtype = 1'b1;
                w_alu   = inst_id[2:0];
                w_wreg  = 1'b1;
                w_rd    = inst_id[11:9];
                w_rs    = inst_id[8:6];
                w_rt    = inst_id[5:3];
            end
            c_OP_ANDI, c_OP_ADDI, c_OP_LW: begin
                w_imm   = 1'b1;
                w_logic = (w_op == c_OP_ANDI);
                w_ld    = (w_op == c_OP_LW);
                w_alu   = (w_op == c_OP_ANDI) ? c_ALU_AND : c_ALU_ADD;
                w_wreg  = 1'b1;
                w_rd    = inst_id[8:6];
                w_rs    = inst_id[11:9];
            end
            c_OP_SW: begin
                w_imm  = 1'b1;
                w_wmem = 1'b1;
                w_alu  = c_ALU_ADD;
                w_rs   = inst_id[11:9];
                w_rt   = inst_id[8:6];
            end
            c_OP_BEQ, c_OP_BNE: begin
                w_br  = 1'b1;
                w_bne = (w_op == c_OP_BNE);
                w_alu = c_ALU_SUB;
                w_rs  = inst_id[11:9];
                w_rt  = inst_id[8:6];
            end
            c_OP_FOR: begin
                w_for  = 1'b1;
                w_alu  = c_ALU_SUB;
                w_wreg = 1'b1;
                w_rd   = inst_id[11:9];
                w_rs   = inst_id[11:9];
            end
            default: ;
        endcase
    end

    assign w_jump_op = (w_op == c_OP_JMP) || (w_op == c_OP_CALL) || (w_op == c_OP_RET);

    // ---------------- pipeline control registers ----------------
    logic              ex_vld_q, ex_imm_q, ex_rtype_q, ex_logic_q, ex_for_q;
    logic              ex_br_q, ex_bne_q, ex_wmem_q, ex_ld_q, ex_wreg_q;
    logic [2:0]        ex_alu_q;
    logic [REG_AW-1:0] ex_rd_q, ex_rs_q, ex_rt_q;
    logic              mem_vld_q, mem_wmem_q, mem_ld_q, mem_wreg_q;
    logic [REG_AW-1:0] mem_rd_q;
    logic              wb_vld_q, wb_ld_q, wb_wreg_q;
    logic [REG_AW-1:0] wb_rd_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    // ---------------- hazard / flow control ----------------
    logic w_load_use, w_id_jump, w_ex_load;

    assign w_load_use = id_valid && ex_vld_q && ex_ld_q && (ex_rd_q != '0) &&
                        ((w_rs == ex_rd_q) || (w_rt == ex_rd_q));
    assign w_id_jump  = id_valid && w_jump_op;
    assign w_ex_load  = id_valid && !idex_flush;

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (rst || !mem_ready) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
        end else if (redirect_ex) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (w_id_jump) begin
            ifid_flush = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!rst && !pc_en && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_vld_q   <= 1'b0;
            ex_alu_q   <= '0;
            ex_imm_q   <= 1'b0;
            ex_rtype_q <= 1'b0;
            ex_logic_q <= 1'b0;
            ex_for_q   <= 1'b0;
            ex_br_q    <= 1'b0;
            ex_bne_q   <= 1'b0;
            ex_wmem_q  <= 1'b0;
            ex_ld_q    <= 1'b0;
            ex_wreg_q  <= 1'b0;
            ex_rd_q    <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            mem_vld_q  <= 1'b0;
            mem_wmem_q <= 1'b0;
            mem_ld_q   <= 1'b0;
            mem_wreg_q <= 1'b0;
            mem_rd_q   <= '0;
            wb_vld_q   <= 1'b0;
            wb_ld_q    <= 1'b0;
            wb_wreg_q  <= 1'b0;
            wb_rd_q    <= '0;
        end else if (mem_ready) begin
            ex_vld_q   <= w_ex_load;
            ex_alu_q   <= w_ex_load ? w_alu : 3'b000;
            ex_imm_q   <= w_ex_load && w_imm;
            ex_rtype_q <= w_ex_load && w_rtype;
            ex_logic_q <= w_ex_load && w_logic;
            ex_for_q   <= w_ex_load && w_for;
            ex_br_q    <= w_ex_load && w_br;
            ex_bne_q   <= w_ex_load && w_bne;
            ex_wmem_q  <= w_ex_load && w_wmem;
            ex_ld_q    <= w_ex_load && w_ld;
            ex_wreg_q  <= w_ex_load && w_wreg;
            ex_rd_q    <= w_ex_load ? w_rd : '0;
            ex_rs_q    <= w_ex_load ? w_rs : '0;
            ex_rt_q    <= w_ex_load ? w_rt : '0;
            mem_vld_q  <= ex_vld_q;
            mem_wmem_q <= ex_wmem_q;
            mem_ld_q   <= ex_ld_q;
            mem_wreg_q <= ex_wreg_q;
            mem_rd_q   <= ex_rd_q;
            wb_vld_q   <= mem_vld_q;
            wb_ld_q    <= mem_ld_q;
            wb_wreg_q  <= mem_wreg_q;
            wb_rd_q    <= mem_rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    // ---------------- forwarding ----------------
    logic w_mem_fwd, w_wb_fwd;

    // A load in EX/MEM has no data yet; its consumer was already stalled.
    assign w_mem_fwd = mem_vld_q && mem_wreg_q && !mem_ld_q;
    assign w_wb_fwd  = wb_vld_q && wb_wreg_q;

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (ex_vld_q && (ex_rs_q != '0)) begin
            if (w_mem_fwd && (mem_rd_q == ex_rs_q))     fwd_a = 2'b01;
            else if (w_wb_fwd && (wb_rd_q == ex_rs_q))  fwd_a = 2'b10;
        end
        if (ex_vld_q && (ex_rt_q != '0)) begin
            if (w_mem_fwd && (mem_rd_q == ex_rt_q))     fwd_b = 2'b01;
            else if (w_wb_fwd && (wb_rd_q == ex_rt_q))  fwd_b = 2'b10;
        end
    end

    // ---------------- outputs ----------------
    logic w_id_ok;
    assign w_id_ok = id_valid && !redirect_ex;

    assign jmp_target      = w_id_ok && ((w_op == c_OP_JMP) || (w_op == c_OP_CALL));
    assign update_rr       = w_id_ok && (w_op == c_OP_CALL);
    assign slect_pc_src_id = w_id_ok && w_jump_op;

    assign alu_control    = ex_vld_q ? ex_alu_q : 3'b000;
    assign imm            = ex_vld_q && ex_imm_q;
    assign r_type         = ex_vld_q && ex_rtype_q;
    assign logical_signal = ex_vld_q && ex_logic_q;
    assign for_signal     = ex_vld_q && ex_for_q;
    assign branch_signal  = ex_vld_q && ex_br_q;
    assign bne            = ex_vld_q && ex_bne_q;
    assign write_to_mem   = mem_vld_q && mem_wmem_q;
    assign load_mem       = mem_vld_q && mem_ld_q;
    assign write_to_reg   = wb_vld_q && wb_wreg_q;
    assign load_wb        = wb_vld_q && wb_ld_q;
    assign wb_rd          = wb_vld_q ? wb_rd_q : '0;
    assign stall_count    = stall_cnt_q;

endmodule
`default_nettype wire
